ft64_irq_target: RTL

//  Per-target interrupt stage that sits directly downstream of the platform interrupt controller.
//  - Consumes one target's 4-bit irq level output, plus the source number and cause of the winning source.
//  - Presents a single request to the core and tracks nested in-service levels on a small stack.
//  - On each take, pulses the controller's acknowledge path so edge sense is reset and rotation advances.

---
 rtl/ft64_irq_target.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ft64_irq_target.sv
// Per-target interrupt stage: presents one request to the core and tracks nested in-service levels.
// Optional withdrawn-request counter enabled by defining FT64_IRQ_SPURIOUS_EN.
module ft64_irq_target #(
  parameter int NEST = 4,
  parameter int SRCW = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      irq_lvl_i,
  input  logic [SRCW-1:0] src_i,
  input  logic [7:0]      cause_i,
  input  logic [3:0]      im_i,
  input  logic            take_i,
  input  logic            eoi_i,
  output logic [3:0]      irq_o,
  output logic [7:0]      cause_o,
  output logic            ack_o,
  output logic [SRCW-1:0] ack_num_o,
  output logic [3:0]      cur_lvl_o,
  output logic            err_o,
  output logic [15:0]     spur_cnt_o
);

  localparam int DW = $clog2(NEST + 1);
  localparam logic [DW-1:0] NEST_D = DW'(NEST);
  localparam logic [DW-1:0] ONE_D  = DW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [3:0]      lvl_r;
  logic [SRCW-1:0] src_r;
  logic [7:0]      cause_r;
  logic [3:0]      pend_lvl_r, pend_lvl_s;
  logic [SRCW-1:0] pend_src_r, pend_src_s;
  logic [7:0]      pend_cause_r, pend_cause_s;
  logic [3:0]      stk_r [NEST];
  logic [3:0]      stk_s [NEST];
  logic [DW-1:0]   depth_r, depth_s, depth_pop_s;
  logic [3:0]      top_s;
  logic            eligible_s;
  logic            push_s;
  logic            withdraw_s;
  logic            err_set_s;
  logic            err_eoi_s;

  // cur_lvl_o is the registered top of the current stack, so it doubles as cur_lvl
  assign eligible_s = (lvl_r != 4'd0) && (lvl_r > cur_lvl_o) && (lvl_r > im_i) && (depth_r < NEST_D);

  // Request FSM: next state, pending request capture and take/withdraw decisions
  always_comb begin
    state_s      = state_r;
    pend_lvl_s   = pend_lvl_r;
    pend_src_s   = pend_src_r;
    pend_cause_s = pend_cause_r;
    push_s       = 1'b0;
    withdraw_s   = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        err_set_s = take_i;
        if (eligible_s) begin
          state_s      = PEND;
          pend_lvl_s   = lvl_r;
          pend_src_s   = src_r;
          pend_cause_s = cause_r;
        end else begin
          state_s = IDLE;
        end
      end
      PEND: begin
        if (take_i) begin
          push_s  = 1'b1;
          state_s = IDLE;
        end else if ((lvl_r == 4'd0) || (lvl_r <= im_i)) begin
          withdraw_s = 1'b1;
          state_s    = IDLE;
        end else if (lvl_r > pend_lvl_r) begin
          pend_lvl_s   = lvl_r;
          pend_src_s   = src_r;
          pend_cause_s = cause_r;
        end else begin
          state_s = PEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // In-service stack: pop on eoi first, then push the taken level on top
  always_comb begin
    depth_pop_s = depth_r;
    err_eoi_s   = 1'b0;
    top_s       = 4'd0;
    stk_s       = stk_r;
    if (eoi_i) begin
      if (depth_r != '0) begin
        depth_pop_s = depth_r - ONE_D;
      end else begin
        err_eoi_s = 1'b1;
      end
    end else begin
      depth_pop_s = depth_r;
    end
    if (push_s && (depth_pop_s < NEST_D)) begin
      depth_s = depth_pop_s + ONE_D;
    end else begin
      depth_s = depth_pop_s;
    end
    for (int i = 0; i < NEST; i++) begin
      if (push_s && (depth_pop_s == DW'(i))) begin
        stk_s[i] = pend_lvl_r;
      end else begin
        stk_s[i] = stk_r[i];
      end
    end
    for (int i = 0; i < NEST; i++) begin
      top_s = (depth_s == DW'(i + 1)) ? stk_s[i] : top_s;
    end
  end

  // State, input stage, stack and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      lvl_r        <= 4'd0;
      src_r        <= '0;
      cause_r      <= 8'd0;
      pend_lvl_r   <= 4'd0;
      pend_src_r   <= '0;
      pend_cause_r <= 8'd0;
      depth_r      <= '0;
      for (int i = 0; i < NEST; i++) begin
        stk_r[i] <= 4'd0;
      end
      irq_o        <= 4'd0;
      cause_o      <= 8'd0;
      ack_o        <= 1'b0;
      ack_num_o    <= '0;
      cur_lvl_o    <= 4'd0;
      err_o        <= 1'b0;
    end else begin
      state_r      <= state_s;
      lvl_r        <= irq_lvl_i;
      src_r        <= src_i;
      cause_r      <= cause_i;
      pend_lvl_r   <= pend_lvl_s;
      pend_src_r   <= pend_src_s;
      pend_cause_r <= pend_cause_s;
      depth_r      <= depth_s;
      stk_r        <= stk_s;
      irq_o        <= (state_s == PEND) ? pend_lvl_s : 4'd0;
      cause_o      <= (state_s == PEND) ? pend_cause_s : cause_o;
      ack_o        <= push_s;
      ack_num_o    <= push_s ? pend_src_r : ack_num_o;
      cur_lvl_o    <= top_s;
      err_o        <= err_o | err_set_s | err_eoi_s;
    end
  end

`ifdef FT64_IRQ_SPURIOUS_EN
  logic [15:0] spur_r;

  // Saturating count of requests withdrawn before the core took them
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      spur_r <= 16'h0000;
    end else if (withdraw_s && (spur_r != 16'hFFFF)) begin
      spur_r <= spur_r + 16'd1;
    end else begin
      spur_r <= spur_r;
    end
  end

  assign spur_cnt_o = spur_r;
`else
  logic spur_unused_s;
  assign spur_unused_s = withdraw_s;
  assign spur_cnt_o    = 16'h0000;
`endif

endmodule
